// File: rtl/mdu_pkg.sv
// Shared op encoding, FSM states and op-classification helpers for the
// iterative multiply/divide unit (mdu_iter).
package mdu_pkg;

  localparam logic [3:0] OP_MUL    = 4'd0;
  localparam logic [3:0] OP_MULH   = 4'd1;
  localparam logic [3:0] OP_MULHSU = 4'd2;
  localparam logic [3:0] OP_MULHU  = 4'd3;
  localparam logic [3:0] OP_DIV    = 4'd4;
  localparam logic [3:0] OP_DIVU   = 4'd5;
  localparam logic [3:0] OP_REM    = 4'd6;
  localparam logic [3:0] OP_REMU   = 4'd7;
  localparam logic [3:0] OP_MULW   = 4'd8;
  localparam logic [3:0] OP_DIVW   = 4'd9;
  localparam logic [3:0] OP_DIVUW  = 4'd10;
  localparam logic [3:0] OP_REMW   = 4'd11;
  localparam logic [3:0] OP_REMUW  = 4'd12;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

  function automatic logic is_valid_op(input logic [3:0] op);
    return op <= OP_REMUW;
  endfunction

  function automatic logic is_word(input logic [3:0] op);
    return (op >= OP_MULW) && (op <= OP_REMUW);
  endfunction

  function automatic logic is_mul(input logic [3:0] op);
    return (op <= OP_MULHU) || (op == OP_MULW);
  endfunction

  function automatic logic is_rem(input logic [3:0] op);
    return (op == OP_REM) || (op == OP_REMU) || (op == OP_REMW) || (op == OP_REMUW);
  endfunction

  function automatic logic is_signed_a(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) ||
           (op == OP_REM) || (op == OP_MULW) || (op == OP_DIVW) || (op == OP_REMW);
  endfunction

  function automatic logic is_signed_b(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM) ||
           (op == OP_MULW) || (op == OP_DIVW) || (op == OP_REMW);
  endfunction

endpackage

// File: rtl/mdu_iter_step.sv
// One iteration of the shared datapath: shift-add multiply step or
// restoring-division trial-subtract step on the {acc, lo} register pair.
module mdu_iter_step #(
  parameter int N = 64
) (
  input  logic         div_i,
  input  logic [N-1:0] acc_i,
  input  logic [N-1:0] lo_i,
  input  logic [N-1:0] opnd_i,
  output logic [N-1:0] acc_o,
  output logic [N-1:0] lo_o
);

  logic [N:0] sum;
  logic [N:0] shl;
  logic [N:0] trial;

  always_comb begin
    sum   = {1'b0, acc_i} + (lo_i[0] ? {1'b0, opnd_i} : '0);
    shl   = {acc_i, lo_i[N-1]};
    trial = shl - {1'b0, opnd_i};
    if (div_i) begin
      // Partial remainder stays below the divisor, so trial[N] is a clean sign bit.
      acc_o = trial[N] ? shl[N-1:0] : trial[N-1:0];
      lo_o  = {lo_i[N-2:0], ~trial[N]};
    end else begin
      acc_o = sum[N:1];
      lo_o  = {sum[0], lo_i[N-1:1]};
    end
  end

endmodule

// File: rtl/mdu_iter.sv
// Multi-cycle RV64M multiply/divide unit with valid/ready handshake.
// Define MDU_FAST_MUL_EN to complete all multiplies in one combinational step.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int N     = 64,
  parameter int CNT_W = $clog2(N) + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         flush,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] res,
  output logic         busy
);

  localparam int H = N / 2;
  localparam logic [N-1:0] MIN_N = {1'b1, {(N-1){1'b0}}};
  localparam logic [H-1:0] MIN_H = {1'b1, {(H-1){1'b0}}};

  state_e           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic             neg_q, neg_d;
  logic [N-1:0]     acc_q, acc_d, lo_q, lo_d, opnd_q, opnd_d, res_q, res_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             word, sa, sb, neg_a, neg_b, ovf;
  logic [N-1:0]     a_ext, b_ext, mag_a, mag_b;
  logic [N-1:0]     step_acc, step_lo;
  logic [2*N-1:0]   prod_it;

  function automatic logic [N-1:0] wsext(input logic [N-1:0] x);
    return {{H{x[H-1]}}, x[H-1:0]};
  endfunction

  function automatic logic [N-1:0] finalize(input logic [3:0] o, input logic ng,
                                            input logic [2*N-1:0] prod,
                                            input logic [N-1:0] q, input logic [N-1:0] r);
    logic [2*N-1:0] p;
    logic [N-1:0]   v;
    p = ng ? -prod : prod;
    if (is_mul(o))
      v = (o == OP_MULH || o == OP_MULHSU || o == OP_MULHU) ? p[2*N-1:N] : p[N-1:0];
    else if (is_rem(o))
      v = ng ? -r : r;
    else
      v = ng ? -q : q;
    return is_word(o) ? wsext(v) : v;
  endfunction

  // Operand conditioning: word truncation/extension, then sign/magnitude split.
  always_comb begin
    word  = is_word(op);
    sa    = is_signed_a(op);
    sb    = is_signed_b(op);
    a_ext = word ? {{H{sa & a[H-1]}}, a[H-1:0]} : a;
    b_ext = word ? {{H{sb & b[H-1]}}, b[H-1:0]} : b;
    neg_a = sa & a_ext[N-1];
    neg_b = sb & b_ext[N-1];
    mag_a = neg_a ? -a_ext : a_ext;
    mag_b = neg_b ? -b_ext : b_ext;
    ovf   = sa & (word ? (a[H-1:0] == MIN_H && b[H-1:0] == '1)
                       : (a == MIN_N && b == '1));
  end

  mdu_iter_step #(.N(N)) u_step (
    .div_i  (~is_mul(op_q)),
    .acc_i  (acc_q),
    .lo_i   (lo_q),
    .opnd_i (opnd_q),
    .acc_o  (step_acc),
    .lo_o   (step_lo)
  );

  // Word multiplies stop after H shifts, leaving the product H bits high.
  assign prod_it = is_word(op_q) ? ({step_acc, step_lo} >> H) : {step_acc, step_lo};

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    neg_d   = neg_q;
    acc_d   = acc_q;
    lo_d    = lo_q;
    opnd_d  = opnd_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (in_valid) begin
          op_d  = op;
          neg_d = is_rem(op) ? neg_a : (neg_a ^ neg_b);
          cnt_d = word ? CNT_W'(H) : CNT_W'(N);
          if (!is_valid_op(op)) begin
            res_d   = '0;
            state_d = S_DONE;
          end else if (!is_mul(op) && b_ext == '0) begin
            res_d   = is_rem(op) ? (word ? wsext(a) : a) : '1;
            state_d = S_DONE;
          end else if (!is_mul(op) && ovf) begin
            res_d   = is_rem(op) ? '0 : (word ? wsext(a) : a);
            state_d = S_DONE;
`ifdef MDU_FAST_MUL_EN
          end else if (is_mul(op)) begin
            res_d   = finalize(op, neg_a ^ neg_b,
                               {{N{1'b0}}, mag_a} * {{N{1'b0}}, mag_b}, '0, '0);
            state_d = S_DONE;
`endif
          end else if (is_mul(op)) begin
            acc_d   = '0;
            lo_d    = mag_b;
            opnd_d  = mag_a;
            state_d = S_CALC;
          end else begin
            acc_d   = '0;
            lo_d    = word ? (mag_a << H) : mag_a;
            opnd_d  = mag_b;
            state_d = S_CALC;
          end
        end
        S_CALC: begin
          acc_d = step_acc;
          lo_d  = step_lo;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            res_d   = finalize(op_q, neg_q, prod_it, step_lo, step_acc);
            state_d = S_DONE;
          end
        end
        S_DONE: if (out_ready) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      neg_q   <= 1'b0;
      acc_q   <= '0;
      lo_q    <= '0;
      opnd_q  <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      acc_q   <= acc_d;
      lo_q    <= lo_d;
      opnd_q  <= opnd_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = ~in_ready;
  assign out_valid = (state_q == S_DONE);
  assign res       = res_q;

endmodule
